fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch stage feeding decode, and through it the exec elements.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage.
// Holds the PC, issues one outstanding instruction-memory read at a time, and
// buffers returned words in a small FIFO that feeds decode. A redirect flushes
// the FIFO and restarts fetch. A response that was already in flight is
// discarded by the S_DRAIN state.
// Optional build macro FETCH_PERF_COUNTERS_EN adds the perf_fetched and
// perf_flushed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reserved;
  logic [31:0]   fifo_inst_q [QUEUE_DEPTH];
  logic [31:0]   fifo_pc_q   [QUEUE_DEPTH];
  logic          accept, push, pop, flush, slot_free;

  // A slot is held for the in-flight word, so a response can never overflow the FIFO
  assign reserved  = count_q + CW'(state_q == S_WAIT);
  assign slot_free = reserved < CW'(QUEUE_DEPTH);

  // All outputs read zero while reset is held
  assign imem_addr  = reset ? pc_q : 32'h0;
  assign inst_valid = (count_q != '0);
  assign inst       = fifo_inst_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  // Next-state and request logic. A redirect overrides everything else
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    imem_req  = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req = reset & slot_free;
        if (imem_req && imem_ready) begin
          pend_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    accept = imem_req & imem_ready;
    if (redirect_valid) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_d  = redirect_pc & ~32'h3;
      // A request that is still in flight, or is accepted this cycle, is stale
      if (state_q == S_REQ) state_d = accept ? S_DRAIN : S_REQ;
      else                  state_d = imem_rvalid ? S_REQ : S_DRAIN;
    end
  end

  // FIFO pointer and occupancy update. A flush wins over a same-cycle pop
  always_comb begin
    pop      = inst_valid & inst_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State, PC and FIFO control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage. Entries are cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_inst_q[i] <= 32'h0;
        fifo_pc_q[i]   <= 32'h0;
      end
    end else if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // Counters wrap naturally on overflow
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'h0, push};
    perf_flushed_d = perf_flushed_q + {31'h0, redirect_valid};
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= 32'h0;
      perf_flushed_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. It has a memory responder
// and a scoreboard. The expected (pc, word) pairs are queued when a request is
// accepted. The queue is flushed on a redirect or a reset. Each decode
// handshake pops one entry and compares it.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready, redirect_valid;
  logic [31:0] inst, inst_pc, redirect_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus controls: mode 0 = never, 1 = always, 2 = random
  int rdy_mode = 1, ird_mode = 1, redir_pct = 0, lat_min = 0, lat_max = 2;
  int redir_req = 0, redir_done = 0;
  logic [31:0] redir_tgt = 32'h0;

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] fetch_pc = RESET_PC;
  logic        acc_seen = 1'b0, flush_chk = 1'b0, prev_stall = 1'b0;
  logic [31:0] acc_addr = 32'h0, prev_addr = 32'h0;
  int          acc_total = 0, pops = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ {a[31:16], 16'h5a3c} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input int mode, input int pct);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(99, 0) < pct);
  endfunction

  // memory responder and random input driver, updates just after each posedge
  initial begin
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          dly = 0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        pend = 1'b0; imem_rvalid = 1'b0;
      end else begin
        if (acc_seen) begin
          pend = 1'b1; pend_addr = acc_addr; dly = $urandom_range(lat_max, lat_min);
        end
        if (pend && dly == 0) begin
          imem_rvalid = 1'b1; imem_rdata = memf(pend_addr); pend = 1'b0;
        end else begin
          imem_rvalid = 1'b0; imem_rdata = $urandom;
          if (pend) dly--;
        end
      end
      imem_ready = pick(rdy_mode, 70);
      inst_ready = pick(ird_mode, 60);
      if (redir_req != redir_done) begin
        redirect_valid = 1'b1; redirect_pc = redir_tgt; redir_done++;
      end else if (reset && $urandom_range(99, 0) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf)) : $urandom;
      end else begin
        redirect_valid = 1'b0; redirect_pc = $urandom;
      end
    end
  end

  // monitor: compares at each negedge, while inputs are stable for the next edge
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete(); fetch_pc = RESET_PC;
        flush_chk = 1'b0; prev_stall = 1'b0; acc_seen = 1'b0;
      end else begin
        if (flush_chk) chk("flush_empty", {31'h0, inst_valid}, 32'h0);
        if (prev_stall) begin
          chk("stall_req", {31'h0, imem_req}, 32'h1);
          chk("stall_addr", imem_addr, prev_addr);
        end
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ghost_inst: got pc %h with nothing expected at %0t", inst_pc, $time);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e[63:32]);
            chk("inst", inst, e[31:0]);
            pops++;
          end
        end
        acc_seen = imem_req && imem_ready;
        if (acc_seen) begin
          chk("imem_addr", imem_addr, fetch_pc);
          acc_addr = imem_addr;
          acc_total++;
          if (!redirect_valid) exp_q.push_back({fetch_pc, memf(fetch_pc)});
          fetch_pc = fetch_pc + 32'd4;
        end
        flush_chk = redirect_valid;
        if (redirect_valid) begin
          exp_q.delete();
          fetch_pc = redirect_pc & ~32'h3;
        end
        prev_stall = imem_req && !imem_ready && !redirect_valid;
        prev_addr  = imem_addr;
      end
    end
  end

  task automatic reset_checks();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
  endtask

  // release reset and check that the first request goes to RESET_PC
  task automatic release_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RESET_PC);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); reset_checks();
    release_reset();
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(imem_req && imem_ready) && n < 50);
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL %s: no accepted request within 50 cycles", name);
    end
  endtask

  // wait (bounded) for the next accepted request and check its address
  task automatic next_addr_check(input string name, input logic [31:0] exp);
    wait_accept(name);
    chk(name, imem_addr, exp);
  endtask

  // fire one redirect; the driver applies it on the next edge
  task automatic request_redirect(input logic [31:0] tgt);
    redir_tgt = tgt;
    redir_req++;
  endtask

  initial begin
    int a0;
    logic [31:0] held;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_checks();

    // 1. 1-cycle memory, free-running fetch from RESET_PC
    lat_min = 0; lat_max = 0; rdy_mode = 1; ird_mode = 1;
    release_reset();
    repeat (40) @(posedge clk);

    // 2. decode stalled: exactly DEPTH requests, then one pop frees one slot
    lat_min = 0; lat_max = 2; ird_mode = 0;
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    a0 = acc_total;
    repeat (20) @(posedge clk);
    chk("fill_accepts", acc_total - a0, DEPTH);
    @(negedge clk); chk("full_no_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #2 ird_mode = 1;
    @(posedge clk); #2 ird_mode = 0;
    repeat (20) @(posedge clk);
    chk("one_pop_one_req", acc_total - a0, DEPTH + 1);
    ird_mode = 1;
    repeat (10) @(posedge clk);

    // 3. redirect to 0x2003 while a response is in flight
    lat_min = 2; lat_max = 3;
    wait_accept("redir_wait_acc");
    request_redirect(32'h0000_2003);
    next_addr_check("redir_wait_addr", 32'h0000_2000);
    repeat (10) @(posedge clk);

    // 4. redirect in the same cycle as the response
    lat_min = 0; lat_max = 0;
    wait_accept("redir_same_acc");
    request_redirect(32'h0000_2000);
    @(negedge clk); @(negedge clk);
    chk("redir_same_req", {31'h0, imem_req}, 32'h1);
    chk("redir_same_addr", imem_addr, 32'h0000_2000);
    repeat (10) @(posedge clk);

    // 5. memory not ready for several cycles: request held, pc not advanced
    lat_max = 2; rdy_mode = 0;
    @(posedge clk); #2;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!imem_req && n < 20);
    end
    held = imem_addr;
    repeat (5) begin
      @(negedge clk);
      chk("hold_req", {31'h0, imem_req}, 32'h1);
      chk("hold_addr", imem_addr, held);
    end
    rdy_mode = 1;
    next_addr_check("hold_release_addr", held);

    // random traffic with redirects, backpressure and variable latency
    rdy_mode = 2; ird_mode = 2; redir_pct = 6; lat_min = 0; lat_max = 3;
    repeat (3000) @(posedge clk);
    redir_pct = 0;
    do_reset();
    repeat (200) @(posedge clk);

    // 6. reset asserted while draining a stale response
    rdy_mode = 1; ird_mode = 1; lat_min = 2; lat_max = 3;
    wait_accept("drain_acc");
    request_redirect(32'h0000_3000);
    @(posedge clk); @(posedge clk); #2 reset = 1'b0;
    #1 reset_checks();
    @(posedge clk);
    release_reset();
    repeat (20) @(posedge clk);

    if (pops < 100) begin
      checks++; errors++;
      $display("FAIL progress: got %0d pops expected at least 100", pops);
    end else checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
